// File: rtl/fp16_align_stage_if.sv
// fp16_align_stage_if: operand-in / aligned-pair-out handshake bundle for the FP16 align stage.
interface fp16_align_stage_if #(parameter int SHIFT_W = 14);
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        a;
    logic [15:0]        b;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         exp_out;
    logic [10:0]        big_mant;
    logic [SHIFT_W-1:0] small_aligned;
    logic               sign_big;
    logic               sign_small;
    logic               swap;
    logic               special;
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, exp_out, big_mant, small_aligned,
               sign_big, sign_small, swap, special
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, exp_out, big_mant, small_aligned,
               sign_big, sign_small, swap, special
    );
endinterface

// File: rtl/fp16_align_stage.sv
// fp16_align_stage: two-stage FP16 operand alignment (compare/order, then shift with G/R/S).
module fp16_align_stage #(parameter int SHIFT_W = 14) (
    input logic clk,
    input logic rst,
    fp16_align_stage_if.slave bus
);
    logic [4:0]         ea_d, eb_d, dabs_d;
    logic [10:0]        ma_d, mb_d;
    logic [5:0]         diff_d, ndiff_d;
    logic               swap_d, accept, s2_adv;
    logic [SHIFT_W-1:0] t_d, small_d;
    logic               lost_d;
    logic               s1_valid_q, s1_sb_q, s1_ss_q, s1_swap_q, s1_sp_q;
    logic [4:0]         s1_exp_q, s1_d_q;
    logic [10:0]        s1_big_q, s1_small_q;
    logic               s2_valid_q, s2_sb_q, s2_ss_q, s2_swap_q, s2_sp_q;
    logic [4:0]         s2_exp_q;
    logic [10:0]        s2_big_q;
    logic [SHIFT_W-1:0] s2_small_q;

    // Subnormals (and zero) use an effective exponent of 1 with no hidden bit.
    always_comb begin
        ea_d    = (bus.a[14:10] != 5'd0) ? bus.a[14:10] : 5'd1;
        eb_d    = (bus.b[14:10] != 5'd0) ? bus.b[14:10] : 5'd1;
        ma_d    = {|bus.a[14:10], bus.a[9:0]};
        mb_d    = {|bus.b[14:10], bus.b[9:0]};
        diff_d  = {1'b0, ea_d} - {1'b0, eb_d};
        ndiff_d = 6'd0 - diff_d;
        swap_d  = diff_d[5] | ((diff_d == 6'd0) && (mb_d > ma_d));
        dabs_d  = diff_d[5] ? ndiff_d[4:0] : diff_d[4:0];
    end

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // Shifts of SHIFT_W or more fall out naturally: the quotient is zero and sticky = |t.
    always_comb begin
        t_d     = {s1_small_q, {(SHIFT_W-11){1'b0}}};
        lost_d  = |(t_d & ~({SHIFT_W{1'b1}} << s1_d_q));
        small_d = (t_d >> s1_d_q) | {{(SHIFT_W-1){1'b0}}, lost_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_d_q     <= '0;
            s1_big_q   <= '0;
            s1_small_q <= '0;
            s1_sb_q    <= 1'b0;
            s1_ss_q    <= 1'b0;
            s1_swap_q  <= 1'b0;
            s1_sp_q    <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_exp_q   <= swap_d ? eb_d : ea_d;
            s1_d_q     <= dabs_d;
            s1_big_q   <= swap_d ? mb_d : ma_d;
            s1_small_q <= swap_d ? ma_d : mb_d;
            s1_sb_q    <= swap_d ? bus.b[15] : bus.a[15];
            s1_ss_q    <= swap_d ? bus.a[15] : bus.b[15];
            s1_swap_q  <= swap_d;
            s1_sp_q    <= (&bus.a[14:10]) | (&bus.b[14:10]);
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_exp_q   <= '0;
            s2_big_q   <= '0;
            s2_small_q <= '0;
            s2_sb_q    <= 1'b0;
            s2_ss_q    <= 1'b0;
            s2_swap_q  <= 1'b0;
            s2_sp_q    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_exp_q   <= s1_exp_q;
                s2_big_q   <= s1_big_q;
                s2_small_q <= small_d;
                s2_sb_q    <= s1_sb_q;
                s2_ss_q    <= s1_ss_q;
                s2_swap_q  <= s1_swap_q;
                s2_sp_q    <= s1_sp_q;
            end
        end
    end

    assign bus.out_valid     = s2_valid_q;
    assign bus.exp_out       = s2_exp_q;
    assign bus.big_mant      = s2_big_q;
    assign bus.small_aligned = s2_small_q;
    assign bus.sign_big      = s2_sb_q;
    assign bus.sign_small    = s2_ss_q;
    assign bus.swap          = s2_swap_q;
    assign bus.special       = s2_sp_q;
endmodule

// File: tb/tb_fp16_align_stage.sv
// tb_fp16_align_stage: directed vectors through a scoreboard queue; a monitor checks every output transfer.
module tb_fp16_align_stage;
    typedef logic [33:0] exp_t;
    logic clk, rst;
    int   n_vec, n_bad;
    exp_t sb[$];

    fp16_align_stage_if #(.SHIFT_W(14)) bus ();
    fp16_align_stage #(.SHIFT_W(14)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] e, input logic [10:0] bm, input logic [13:0] sm,
                                input logic sgb, input logic sgs, input logic sw, input logic sp);
        return {e, bm, sm, sgb, sgs, sw, sp};
    endfunction

    function automatic exp_t got();
        return {bus.exp_out, bus.big_mant, bus.small_aligned, bus.sign_big,
                bus.sign_small, bus.swap, bus.special};
    endfunction

    task automatic chk(input string nm, input exp_t act, input exp_t req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("unexpected_output", got(), 34'h0 ^ {34{1'bx}});
            else chk("output", got(), sb.pop_front());
        end
    end

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input exp_t e);
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 34'd0, 34'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        #2 chk("reset_out_valid", 34'(bus.out_valid), 34'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_in_ready", 34'(bus.in_ready), 34'd1);
        send(16'h3C00, 16'h3C00, mk(5'd15, 11'h400, 14'h2000, 0, 0, 0, 0));
        send(16'h3C00, 16'h4800, mk(5'd18, 11'h400, 14'h0400, 0, 0, 1, 0));
        send(16'h7800, 16'h0001, mk(5'd30, 11'h400, 14'h0001, 0, 0, 0, 0));
        send(16'h4C00, 16'h3C01, mk(5'd19, 11'h400, 14'h0201, 0, 0, 0, 0));
        send(16'hBC00, 16'h3C00, mk(5'd15, 11'h400, 14'h2000, 1, 0, 0, 0));
        send(16'h3C00, 16'h3C01, mk(5'd15, 11'h401, 14'h2000, 0, 0, 1, 0));
        send(16'h0000, 16'h0000, mk(5'd1,  11'h000, 14'h0000, 0, 0, 0, 0));
        send(16'h0000, 16'h8001, mk(5'd1,  11'h001, 14'h0000, 1, 0, 1, 0));
        send(16'h7BFF, 16'h4BFF, mk(5'd30, 11'h7FF, 14'h0003, 0, 0, 0, 0));
        send(16'h3C00, 16'h0400, mk(5'd15, 11'h400, 14'h0001, 0, 0, 0, 0));
        send(16'h3C00, 16'h0800, mk(5'd15, 11'h400, 14'h0001, 0, 0, 0, 0));
        send(16'h7C00, 16'h3C00, mk(5'd31, 11'h400, 14'h0001, 0, 0, 0, 1));
        send(16'hC000, 16'h3400, mk(5'd16, 11'h400, 14'h0400, 1, 0, 0, 0));
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(16'h3C00, 16'h4000, mk(5'd16, 11'h400, 14'h1000, 0, 0, 1, 0));
        send(16'h4400, 16'h3C00, mk(5'd17, 11'h400, 14'h0800, 0, 0, 0, 0));
        bus.in_valid = 1'b1;
        bus.a = 16'h3800;
        bus.b = 16'h3800;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", 34'(bus.in_ready), 34'd0);
            chk("stall_out_valid", 34'(bus.out_valid), 34'd1);
            if (sb.size() > 0) chk("stall_hold", got(), sb[0]);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(16'h3800, 16'h3800, mk(5'd14, 11'h400, 14'h2000, 0, 0, 0, 0));
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        #1 chk("drain_empty", 34'(sb.size()), 34'd0);
        bus.out_ready = 1'b0;
        send(16'h4000, 16'h3C00, mk(5'd16, 11'h400, 14'h1000, 0, 0, 0, 0));
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(posedge clk);
        #1 chk("pre_reset_valid", 34'(bus.out_valid), 34'd1);
        rst = 1'b1;
        #1 chk("async_reset_clears", 34'(bus.out_valid), 34'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("post_reset_in_ready", 34'(bus.in_ready), 34'd1);
        send(16'h3C00, 16'h4800, mk(5'd18, 11'h400, 14'h0400, 0, 0, 1, 0));
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        #1 chk("final_drain", 34'(sb.size()), 34'd0);
        repeat (3) @(negedge clk);
        chk("no_extra_output", 34'(bus.out_valid), 34'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
